// File: rtl/spiker_result_serializer.sv
// rtl/spiker_result_serializer.sv - captures a spike result vector and streams it out as WIDTH-bit words
module spiker_result_serializer #(
    parameter  int WIDTH    = 32,
    parameter  int N_SPIKES = 784,
    localparam int N_WORDS  = (N_SPIKES + WIDTH - 1) / WIDTH,
    localparam int IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1,
    localparam int CNT_W    = $clog2(N_SPIKES + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [N_SPIKES-1:0] spikes_i,
    input  logic                clr_overrun_i,
    output logic [WIDTH-1:0]    word_o,
    output logic [IDX_W-1:0]    word_idx_o,
    output logic                valid_o,
    output logic                last_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    spike_count_o,
    output logic                overrun_o
);

    localparam int PAD_W = N_WORDS * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PAD_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               overrun_q, overrun_d;
    logic [WIDTH-1:0]   word;

    function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] w);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(w[i]);
        end
        return c;
    endfunction

    // Shadow is padded to a whole number of words so the tail word reads zeros.
    always_comb begin
        word = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                word = shadow_q[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;

        if (start_i && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    shadow_d                 = '0;
                    shadow_d[N_SPIKES-1:0]   = spikes_i;
                    idx_d                    = '0;
                    cnt_d                    = '0;
                    state_d                  = SEND;
                end
            end
            SEND: begin
                if (ready_i) begin
                    cnt_d = cnt_q + popcnt(word);
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign word_o        = word;
    assign word_idx_o    = idx_q;
    assign valid_o       = (state_q == SEND);
    assign last_o        = (state_q == SEND) && (idx_q == LAST_IDX);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DONE);
    assign spike_count_o = cnt_q;
    assign overrun_o     = overrun_q;

endmodule
